hamming_secded_decoder: RTL and testbench
=========================================

Name: hamming_secded_decoder

Overview:
- Parametrised pipelined SECDED decoder: extended Hamming code with an overall parity bit, for any data width.
- Corrects single-bit errors, detects double-bit errors, reports syndrome and status.
- Keeps saturating error counters for system monitoring.
- Sits between memory/link receive logic and the consumer, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 4: data bits per word; must be ≥ 1.
- R, derived (localparam): smallest R with 2^R ≥ DATA_W+R+1; 3 for DATA_W=4, 4 for DATA_W=8.
- CW_W, derived (localparam): DATA_W+R+1; 8 for DATA_W=4.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept a codeword.
- in_codeword  in  CW_W  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  R  Hamming syndrome of the word.
- out_status  out  2  ecc_status_e: 0 OK, 1 CORRECTED, 2 UNCORRECTABLE.
- clr_cnt  in  1  synchronous counter clear.
- cnt_corr  out  CNT_W  number of corrected words delivered.
- cnt_uncorr  out  CNT_W  number of uncorrectable words delivered.

Behaviour:
- Codeword layout:
  - Bit 0 is overall parity (even over all CW_W bits).
  - Bit i (1..CW_W-1) is Hamming position i; powers of two are check bits.
  - Data bits fill the non-power-of-two positions in ascending order, data[0] lowest.
- Stage 1, on input handshake:
  - Register the codeword.
  - Syndrome s = XOR of indices i ≥ 1 whose bit is 1.
  - p = XOR of all CW_W bits.
- Stage 2 classification:
  - s=0, p=0: OK; data extracted unchanged.
  - s=0, p=1: bit 0 in error; CORRECTED, data unchanged.
  - s≠0, p=1, s ≤ CW_W-1: flip bit s, then extract; CORRECTED.
  - s≠0, p=1, s > CW_W-1: UNCORRECTABLE; raw data extracted.
  - s≠0, p=0: double error; UNCORRECTABLE, raw data extracted.
- out_syndrome always carries s.
- Pipeline and handshake:
  - Two register stages; latency is exactly 2 cycles from input handshake to out_valid when unstalled.
  - Throughput: 1 word/cycle.
  - adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational).
  - out_valid = v2. Outputs hold stable while out_valid && !out_ready.
  - No bubbles are inserted; a full pipeline holds 2 words.
- Counters:
  - Increment on the output handshake when status is CORRECTED or UNCORRECTABLE respectively.
  - Saturate at all-ones, never wrap.
  - clr_cnt has priority over a same-cycle increment; the result is 0.
- Reset:
  - rst_n=0 clears v1, v2 and both counters; out_valid=0, out_data=0, out_syndrome=0, out_status=OK.
  - in_ready=1 after the reset cycle.
  - In-flight words are discarded; reset mid-stall drops both stages.

Decomposition:
- hamming_ecc_pkg:
  - ecc_status_e typedef.
  - Function calc_r(data_w).
  - Function is_pow2(i).
  - Function extract_data for position mapping (shared with a future encoder).
- Sub-module hamming_syndrome_calc (combinational, params CW_W/R): codeword in → syndrome and overall parity out. Used in stage 1.

Test Plan:
- DATA_W=4, in_codeword=8'hAA, out_ready=1 → 2 cycles later: out_data=4'b1011, syndrome=3'd0, status OK; counters stay 0.
- 8'h8A (position 5 flipped) → out_data=4'b1011, syndrome=3'd5, CORRECTED; cnt_corr=1.
- 8'hAB (bit 0 flipped) → out_data=4'b1011, syndrome=0, CORRECTED. 8'hE2 (positions 3,6 flipped) → syndrome=3'd5, UNCORRECTABLE; cnt_uncorr=1.
- Back-to-back stream of 3 words with out_ready low for 4 cycles:
  - in_ready drops after 2 words accepted.
  - Outputs are held stable during the stall.
  - All 3 words are delivered in order with no loss or duplication.
- Saturation and clear:
  - Force CNT_W=2; send 5 corrected words → cnt_corr=3.
  - Assert clr_cnt in the same cycle as a corrected handshake → cnt_corr=0.
- Reset and wider data:
  - rst_n low mid-stall with 2 words in flight → out_valid=0 next cycle and both counters 0.
  - DATA_W=8 (CW_W=13), random data with every single-bit flip → all CORRECTED with correct data.

Source files
------------

// File: rtl/hamming_ecc_pkg.sv
// Shared SECDED definitions: status codes and codeword position helpers.
// Used by the decoder today and intended for a matching encoder.
package hamming_ecc_pkg;

  typedef enum logic [1:0] {
    ECC_OK        = 2'd0,
    ECC_CORRECTED = 2'd1,
    ECC_UNCORR    = 2'd2
  } ecc_status_e;

  // Upper bound on codeword width handled by extract_data.
  localparam int MAX_CW = 128;
  localparam int MAX_DW = 128;

  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  // Data bits live at the non-power-of-two positions, data[0] lowest.
  function automatic logic [MAX_DW-1:0] extract_data(input logic [MAX_CW-1:0] cw,
                                                     input int cw_w);
    logic [MAX_DW-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < MAX_CW; i++) begin
      if (i < cw_w && !is_pow2(i)) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module hamming_syndrome_calc #(
  parameter int CW_W = 8,
  parameter int R    = 3
) (
  input  logic [CW_W-1:0] codeword,
  output logic [R-1:0]    syndrome,
  output logic            parity
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (codeword[i]) syndrome = syndrome ^ R'(i);
    end
  end

  assign parity = ^codeword;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready on both sides and saturating
// corrected/uncorrectable word counters.
module hamming_secded_decoder
  import hamming_ecc_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int R      = calc_r(DATA_W),
  localparam int CW_W   = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output ecc_status_e       out_status,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              v1, v2, adv1, adv2;
  logic [CW_W-1:0]   cw1, cw_fix;
  logic [R-1:0]      s1, s_calc;
  logic              p1, p_calc;
  ecc_status_e       st;
  logic [MAX_DW-1:0] dext;
  logic              unused_hi;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  hamming_syndrome_calc #(.CW_W(CW_W), .R(R)) u_syn (
    .codeword (in_codeword),
    .syndrome (s_calc),
    .parity   (p_calc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      cw1 <= '0;
      s1  <= '0;
      p1  <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        cw1 <= in_codeword;
        s1  <= s_calc;
        p1  <= p_calc;
      end
    end
  end

  // Odd parity with a nonzero in-range syndrome is a single flip at position s.
  always_comb begin
    cw_fix = cw1;
    st     = ECC_OK;
    if (s1 == '0) begin
      st = p1 ? ECC_CORRECTED : ECC_OK;
    end else if (p1 && (int'(s1) <= CW_W - 1)) begin
      cw_fix = cw1 ^ (CW_W'(1) << s1);
      st     = ECC_CORRECTED;
    end else begin
      st = ECC_UNCORR;
    end
  end

  assign dext      = extract_data(MAX_CW'(cw_fix), CW_W);
  assign unused_hi = ^dext[MAX_DW-1:DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2           <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_status   <= ECC_OK;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data     <= dext[DATA_W-1:0];
        out_syndrome <= s1;
        out_status   <= st;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (v2 && out_ready) begin
      if (out_status == ECC_CORRECTED && cnt_corr != '1)  cnt_corr   <= cnt_corr + 1'b1;
      if (out_status == ECC_UNCORR && cnt_uncorr != '1)   cnt_uncorr <= cnt_uncorr + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: vector table, stall/reset/counter
// sequences, randomized stream with a scoreboard, and a DATA_W=8 sweep.
module tb_hamming_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [7:0]  in_codeword;
  logic [3:0]  out_data;
  logic [2:0]  out_syndrome;
  logic [1:0]  out_status;
  logic [15:0] cnt_corr, cnt_uncorr;

  logic        s_in_ready, s_out_valid;
  logic [3:0]  s_out_data;
  logic [2:0]  s_out_syndrome;
  logic [1:0]  s_out_status;
  logic [1:0]  s_cnt_corr, s_cnt_uncorr;

  logic        in8_valid, in8_ready, out8_valid, out8_ready, clr8;
  logic [12:0] cw8;
  logic [7:0]  out8_data;
  logic [3:0]  out8_syn;
  logic [1:0]  out8_status;
  logic [15:0] cnt8_corr, cnt8_uncorr;

  always #5 clk = ~clk;

  hamming_secded_decoder #(.DATA_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome), .out_status(out_status),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr));

  hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_codeword(in_codeword), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_syndrome(s_out_syndrome), .out_status(s_out_status),
    .clr_cnt(clr_cnt), .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr));

  hamming_secded_decoder #(.DATA_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_codeword(cw8), .out_valid(out8_valid), .out_ready(out8_ready),
    .out_data(out8_data), .out_syndrome(out8_syn), .out_status(out8_status),
    .clr_cnt(clr8), .cnt_corr(cnt8_corr), .cnt_uncorr(cnt8_uncorr));

  int n_chk = 0, n_fail = 0;
  int delivered = 0, mcorr = 0, muncorr = 0;
  bit mon_en = 0, rand_rdy = 0;

  typedef struct { logic [3:0] d; logic [2:0] s; logic [1:0] st; } exp_t;
  exp_t q[$];

  typedef struct { logic [7:0] cw; logic [3:0] d; logic [2:0] s; logic [1:0] st; } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode straight from the code rules: syndrome = XOR of set indices,
  // even overall parity, data at non-power-of-two positions.
  function automatic void model(input logic [15:0] cw, input int cw_w,
                                output logic [15:0] d, output logic [15:0] s,
                                output logic [1:0] st);
    int syn = 0;
    bit p = 0;
    int k = 0;
    logic [15:0] f = cw;
    for (int i = 0; i < cw_w; i++)
      if (cw[i]) begin p ^= 1'b1; syn ^= i; end
    if (syn == 0) st = p ? 2'd1 : 2'd0;
    else if (p && syn < cw_w) begin f[syn] = ~f[syn]; st = 2'd1; end
    else st = 2'd2;
    d = '0;
    for (int i = 3; i < cw_w; i++)
      if ((i & (i - 1)) != 0) begin d[k] = f[i]; k++; end
    s = syn[15:0];
  endfunction

  function automatic logic [15:0] enc8(input logic [7:0] d);
    logic [15:0] c = '0;
    int k = 0;
    for (int i = 3; i < 13; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
    for (int j = 0; j < 4; j++) begin
      bit x = 0;
      for (int i = 1; i < 13; i++) if (((i >> j) & 1) != 0) x ^= c[i];
      c[1 << j] = x;
    end
    c[0] = ^c[12:1];
    return c;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) check("mon_spurious_out", 32'd1, 32'd0);
        else begin
          check("mon_data", 32'(out_data), 32'(q[0].d));
          check("mon_syndrome", 32'(out_syndrome), 32'(q[0].s));
          check("mon_status", 32'(out_status), 32'(q[0].st));
          if (out_ready) begin
            if (q[0].st == 2'd1) mcorr++;
            if (q[0].st == 2'd2) muncorr++;
            void'(q.pop_front());
            delivered++;
          end
        end
      end
      if (in_valid && in_ready) begin
        logic [15:0] md, ms;
        logic [1:0]  mst;
        exp_t e;
        model({8'h0, in_codeword}, 8, md, ms, mst);
        e.d = md[3:0]; e.s = ms[2:0]; e.st = mst;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [7:0] cw);
    bit ok = 0;
    in_valid = 1'b1;
    in_codeword = cw;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec, eu, base;
    vt[0] = '{8'hAA, 4'b1011, 3'd0, 2'd0};
    vt[1] = '{8'h8A, 4'b1011, 3'd5, 2'd1};
    vt[2] = '{8'hAB, 4'b1011, 3'd0, 2'd1};
    vt[3] = '{8'hE2, 4'b1110, 3'd5, 2'd2};
    vt[4] = '{8'h00, 4'b0000, 3'd0, 2'd0};
    vt[5] = '{8'hFF, 4'b1111, 3'd0, 2'd0};
    vt[6] = '{8'h01, 4'b0000, 3'd0, 2'd1};
    vt[7] = '{8'h06, 4'b0000, 3'd3, 2'd2};
    vt[8] = '{8'h08, 4'b0000, 3'd3, 2'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    in8_valid = 1'b0; cw8 = '0; out8_ready = 1'b1; clr8 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_status", 32'(out_status), 32'd0);
    check("reset_cnt_corr", 32'(cnt_corr), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Vector table: one word at a time, fixed 2-cycle latency.
    ec = 0; eu = 0;
    foreach (vt[k]) begin
      in_valid = 1'b1; in_codeword = vt[k].cw;
      tick();
      in_valid = 1'b0;
      check("lat_not_early", 32'(out_valid), 32'd0);
      tick();
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_data", 32'(out_data), 32'(vt[k].d));
      check("vec_syndrome", 32'(out_syndrome), 32'(vt[k].s));
      check("vec_status", 32'(out_status), 32'(vt[k].st));
      if (vt[k].st == 2'd1) ec++;
      if (vt[k].st == 2'd2) eu++;
      tick();
      check("vec_cnt_corr", 32'(cnt_corr), 32'(ec));
      check("vec_cnt_uncorr", 32'(cnt_uncorr), 32'(eu));
    end

    // Stall: two words fill the pipe, third waits, outputs hold.
    mon_en = 1; base = delivered;
    out_ready = 1'b0;
    push(8'hE2);
    push(8'h8A);
    in_valid = 1'b1; in_codeword = 8'hAA;
    #1 check("stall_in_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_held_data", 32'(out_data), 32'hE);
      check("stall_held_status", 32'(out_status), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    push(8'hAA);
    drain();
    check("stall_delivered", 32'(delivered - base), 32'd3);

    // Reset with two words in flight.
    out_ready = 1'b0;
    push(8'h8A);
    push(8'hE2);
    check("pre_reset_full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    q.delete();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    check("rst_cnt_corr", 32'(cnt_corr), 32'd0);
    check("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sat_out_valid", 32'(s_out_valid), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    // Saturation on the CNT_W=2 instance, then clear-vs-increment priority.
    for (int n = 0; n < 5; n++) push(8'h8A);
    drain();
    check("sat_cnt_corr", 32'(s_cnt_corr), 32'd3);
    check("nosat_cnt_corr", 32'(cnt_corr), 32'd5);
    check("sat_cnt_uncorr", 32'(s_cnt_uncorr), 32'd0);
    push(8'h8A);
    tick();
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_wins_corr", 32'(cnt_corr), 32'd0);
    check("clr_wins_sat", 32'(s_cnt_corr), 32'd0);
    q.delete();

    // Random stream with random gaps and backpressure.
    mcorr = 0; muncorr = 0; base = delivered;
    rand_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      push(8'($urandom));
    end
    rand_rdy = 0; out_ready = 1'b1;
    drain();
    check("rand_delivered", 32'(delivered - base), 32'd150);
    check("rand_cnt_corr", 32'(cnt_corr), 32'(mcorr));
    check("rand_cnt_uncorr", 32'(cnt_uncorr), 32'(muncorr));
    mon_en = 0;

    // DATA_W=8: every single-bit flip (and no flip) of random encoded words.
    for (int w = 0; w < 10; w++) begin
      logic [7:0]  d;
      logic [15:0] c;
      d = 8'($urandom);
      c = enc8(d);
      for (int b = -1; b < 13; b++) begin
        logic [15:0] cf;
        cf = c;
        if (b >= 0) cf[b] = ~cf[b];
        in8_valid = 1'b1; cw8 = cf[12:0];
        tick();
        in8_valid = 1'b0;
        tick();
        check("w8_valid", 32'(out8_valid), 32'd1);
        check("w8_data", 32'(out8_data), 32'(d));
        check("w8_status", 32'(out8_status), (b < 0) ? 32'd0 : 32'd1);
        check("w8_syndrome", 32'(out8_syn), (b <= 0) ? 32'd0 : 32'(b));
      end
    end
    tick();
    check("w8_cnt_corr", 32'(cnt8_corr), 32'd130);
    check("w8_cnt_uncorr", 32'(cnt8_uncorr), 32'd0);
    check("w8_in_ready", 32'(in8_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
